// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file write-back buffer and the
// pipeline stages that feed it.
package regfile_write_buffer_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  // Register x0 is hardwired; writes to it are dropped and reads never bypass.
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_buffer_wb_bypass_match.sv
// Youngest-match search over the pending write entries for one read address.
// Valid entries are contiguous from head, so the last match in age order wins.
module wb_bypass_match
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]             rs,
  input  logic [PTR_W-1:0]              head,
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  rds,
  input  logic [DEPTH-1:0][DATA_W-1:0]  datas,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (rds[idx] == rs) && (rs != ADDR_W'(REG_ZERO))) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// Circular write-back queue in front of the register file write port, with
// newest-match bypass for the two decode read addresses.
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              drain_en,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic                         push;
  logic                         pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

  // A handshake with rd==0 completes but stores nothing.
  assign push = in_valid && in_ready && (in_rd != ADDR_W'(REG_ZERO));
  assign pop  = drain_en && !empty;

  assign RegWrite  = pop;
  assign RD        = empty ? '0 : rd_q[head];
  assign WriteData = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      // tail==head only when empty (no pop) or full (no push), so no conflict.
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= in_rd;
      data_q[tail] <= in_data;
    end
  end

  wb_bypass_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match1 (
    .rs   (RS1),
    .head (head),
    .valid(valid_q),
    .rds  (rd_q),
    .datas(data_q),
    .hit  (hit1),
    .data (byp_data1)
  );

  wb_bypass_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match2 (
    .rs   (RS2),
    .head (head),
    .valid(valid_q),
    .rds  (rd_q),
    .datas(data_q),
    .hit  (hit2),
    .data (byp_data2)
  );

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Small circular write-back queue sitting between execute/memory result producers and the 32x64 register file write port (WriteData/RD/RegWrite).
- Buffers up to DEPTH pending register writes, drains one per cycle into the register file when enabled, and supplies newest-match bypass data for the two read addresses so decode never reads a stale value.

Parameters:
- DEPTH, 4, number of queued writes; power of two, minimum 2.
- DATA_W, 64, register data width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_valid  in  1  producer has a result.
- in_rd  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- in_ready  out  1  buffer accepts this cycle (= !full).
- drain_en  in  1  register file port available; pop allowed.
- RegWrite  out  1  write strobe to register file.
- RD  out  ADDR_W  write address to register file.
- WriteData  out  DATA_W  write data to register file.
- RS1, RS2  in  ADDR_W  decode read addresses, for bypass lookup.
- hit1, hit2  out  1  pending entry matches RS1/RS2.
- byp_data1, byp_data2  out  DATA_W  newest matching pending data; 0 when no hit.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty, full  out  1  count==0 / count==DEPTH.

Behaviour:
- Storage: DEPTH entries of {rd, data}; head/tail pointers wrap modulo DEPTH; occupancy tracked by count, not by pointer compare.
- Push: occurs when in_valid && in_ready && in_rd!=0. Stores at tail, advances tail, visible from the next cycle.
- Push with in_rd==0: handshake completes, but nothing is stored and count is unchanged.
- Pop: occurs when drain_en && !empty. Advances head on the edge.
- Write-port outputs are combinational from head:
  - RegWrite = drain_en && !empty.
  - RD and WriteData = head entry; RD=0 and WriteData=0 when empty.
  - The register file captures on the same edge as the pop, so write latency from push is 1 cycle minimum when the queue is empty and drain_en=1.
- Simultaneous push and pop: both take effect, count unchanged. When full, in_ready=0, so no push occurs even if a pop happens that cycle. Full is never bypassed.
- Ordering: strict FIFO. Two writes to the same rd reach the register file in arrival order.
- Bypass:
  - Compares RS1/RS2 against every stored valid entry, including the head entry being popped this cycle.
  - Selects the youngest match (closest to tail).
  - RS==0 never hits.
  - An entry being pushed in the current cycle is not visible.
  - Purely combinational; zero latency.
- Reset: head=tail=0, count=0, all valid bits cleared. RegWrite=0, hit1=hit2=0, byp_data=0, in_ready=1, empty=1, full=0. Entry data need not be cleared.
- Reset mid-operation: pending writes are discarded, not drained. Reset wins over a simultaneous push or pop.
- drain_en=0: queue holds and RegWrite=0. Bypass stays live.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant (5'd0), and a wb_entry struct {rd, data} reusable by the pipeline.
- One natural sub-module: wb_bypass_match, the combinational youngest-match priority search. It is instantiated twice, once for RS1 and once for RS2.
- Pointer/count control stays in the top module.

Test Plan:
- Reset, then drain_en=1, push rd=5 data=0xAA → next cycle RegWrite=1, RD=5, WriteData=0xAA; following cycle empty=1, RegWrite=0.
- drain_en=0, push rd=1..4 data=0x10..0x40 → full=1, in_ready=0, count=4. Fifth push is ignored. Raising drain_en outputs RD=1,2,3,4 on consecutive cycles.
- drain_en=0, push rd=7 data=0x1 then rd=7 data=0x2, RS1=7 → hit1=1, byp_data1=0x2. RS2=3 → hit2=0, byp_data2=0.
- Push rd=0 data=0xFF → in_ready=1, count stays 0, RegWrite never asserted. RS1=0 → hit1=0.
- Queue at count=2, drain_en=1, push every cycle → count holds at 2 and write order is preserved across pointer wrap (8+ pushes).
- Queue full, assert reset for one cycle alongside a push → count=0, empty=1, RegWrite=0; no queued write ever appears on RD.
